// File: rtl/req_priority_encoder_pkg.sv
// Shared types, sizes and selection helpers for the request priority encoder.
// Both selection policies live here so the top and any reuse see one definition.
package req_priority_encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = $clog2(N_REQ);
  localparam bit RR_EN_DEFAULT = 1'b0;

  typedef logic [N_REQ-1:0]  req_vec_t;
  typedef logic [CODE_W-1:0] code_t;

  // Highest set index wins; returns 0 for an empty vector (caller gates on |v).
  function automatic code_t prio_hi(input req_vec_t v);
    code_t idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = code_t'(i);
    end
    return idx;
  endfunction

  // First set index scanning ptr+1, ptr+2, ... modulo N_REQ, so the last grant
  // is the lowest priority on the next pick.
  function automatic code_t rr_pick(input req_vec_t v, input code_t ptr);
    code_t idx;
    code_t cand;
    logic  found;
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = code_t'(int'(ptr) + k);
      if (!found && v[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_priority_encoder_if.sv
// Request/grant bundle between the request sources, the encoder and the
// downstream dispatch logic; the encoder is the slave side.
interface req_priority_encoder_if;
  import req_priority_encoder_pkg::*;

  req_vec_t req_in;
  req_vec_t req_mask;
  req_vec_t pending;
  code_t    code_out;
  logic     code_valid;
  logic     code_ready;
  logic     ovf;

  modport master (
    output req_in, req_mask, code_ready,
    input  code_out, code_valid, pending, ovf
  );

  modport slave (
    input  req_in, req_mask, code_ready,
    output code_out, code_valid, pending, ovf
  );

endinterface

// File: rtl/decoder_3_8.sv
// Enabled binary-to-one-hot decoder; used to turn an accepted index into the
// pending-bit clear mask.
module decoder_3_8
  import req_priority_encoder_pkg::*;
(
  input  logic     en,
  input  code_t    code,
  output req_vec_t onehot
);

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/req_priority_encoder.sv
// Latches request lines into a pending register and presents one selected
// index at a time on a valid/ready output, clearing the bit when it is taken.
module req_priority_encoder
  import req_priority_encoder_pkg::*;
#(
  parameter bit RR_EN = RR_EN_DEFAULT
)(
  input  logic clk,
  input  logic rst,
  req_priority_encoder_if.slave bus
);

  req_vec_t pending_q;
  code_t    code_q;
  logic     valid_q;
  logic     ovf_q;
  code_t    rr_ptr_q;

  logic     acc;
  logic     load;
  req_vec_t clr;
  req_vec_t elig;
  code_t    sel;

  assign acc  = valid_q & bus.code_ready;
  assign load = ~valid_q | acc;

  decoder_3_8 u_clr_dec (
    .en     (acc),
    .code   (code_q),
    .onehot (clr)
  );

  // Registered pending only: a request is never eligible in the cycle it
  // arrives, and the bit being handed over right now is excluded.
  assign elig = pending_q & bus.req_mask & ~clr;

  always_comb begin
    sel = RR_EN ? rr_pick(elig, rr_ptr_q) : prio_hi(elig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      rr_ptr_q  <= code_t'(N_REQ - 1);
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // here samples the pre-edge values, independent of statement order.
      // A new request on the bit being cleared this cycle wins and re-arms it.
      pending_q <= (pending_q & ~clr) | bus.req_in;
      ovf_q     <= |(bus.req_in & pending_q & ~clr);
      // Output is held while the consumer stalls; an empty pick keeps code_q.
      if (load) begin
        valid_q <= |elig;
        if (|elig) code_q <= sel;
      end
      if (acc) rr_ptr_q <= code_q;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.ovf        = ovf_q;

endmodule
